seg7_scan_driver: RTL
=====================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000, clock cycles each digit spends in SHOW, legal range 2 or more.
REQ-003 Parameter BLANK_CYCLES, default 16, clock cycles of anode-off guard before each digit, legal range 0 or more.
REQ-004 Parameter ACTIVE_LOW, default 1; 1 = common-anode board (segments, dp and anodes active-low), 0 = all active-high.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  system clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 enable  in  1  1 = scan display, 0 = display dark.
REQ-009 load  in  1  single-cycle strobe that captures value_in/dp_in into the shadow register.
REQ-010 value_in  in  4*NUM_DIGITS  hex nibbles, digit k = bits [4k+3:4k], digit 0 rightmost.
REQ-011 dp_in  in  NUM_DIGITS  decimal point request per digit.
REQ-012 blank_lz  in  1  1 = suppress leading zeros.
REQ-013 seg_out  out  7  segments, bit6=a ... bit0=g.
REQ-014 dp_out  out  1  decimal point.
REQ-015 an_out  out  NUM_DIGITS  digit anodes, bit k drives digit k.
REQ-016 digit_idx  out  3  index of the digit currently in BLANK/SHOW.
REQ-017 frame_done  out  1  one-cycle pulse when digit NUM_DIGITS-1 finishes SHOW.

Function
REQ-018 States SHALL be OFF, BLANK and SHOW; a cycle counter SHALL time BLANK and SHOW.
REQ-019 OFF->BLANK when enable=1 (OFF->SHOW if BLANK_CYCLES=0); BLANK->SHOW after BLANK_CYCLES cycles; SHOW->BLANK (or SHOW) after REFRESH_DIV cycles with digit_idx advanced.
REQ-020 digit_idx SHALL wrap NUM_DIGITS-1 -> 0, and frame_done SHALL pulse in the cycle of that wrap.
REQ-021 enable=0 in any state SHALL force OFF on the next clock, with digit_idx=0 and counter=0.
REQ-022 On load=1, the shadow register SHALL capture value_in and dp_in at that clock edge; the new value SHALL be displayed from the next registered output onward, including mid-SHOW.
REQ-023 Glyphs (abcdefg, 1=lit): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-024 In leading-zero blanking, digit k (k>0) SHALL be blanked when blank_lz=1 and all shadow nibbles k..NUM_DIGITS-1 are zero; digit 0 is never blanked; a blanked digit SHALL keep its anode inactive for the whole SHOW slot.
REQ-025 In SHOW, only an_out[digit_idx] SHALL be active; in OFF and BLANK, all anodes SHALL be inactive and seg_out and dp_out SHALL be unlit.
REQ-026 ACTIVE_LOW=1 SHALL invert seg_out, dp_out and an_out relative to the lit/active sense.
REQ-027 seg_out, dp_out and an_out SHALL be registered, lagging the state/digit_idx by one cycle.
REQ-028 Under steady enable, the frame period SHALL be NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.

Reset
REQ-029 On rst, the block SHALL enter OFF with counter=0, digit_idx=0, shadow=0, frame_done=0, seg_out/dp_out unlit and all anodes inactive (ACTIVE_LOW=1: seg_out=7'h7F, dp_out=1, an_out=all ones).
REQ-030 A reset asserted mid-SHOW SHALL reach the REQ-029 values immediately, without waiting for a clock; after release, scanning SHALL restart at digit 0 with BLANK.

Verification
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1.
REQ-031 Reset -> seg_out=7'h7F, dp_out=1, an_out=4'hF, digit_idx=0, frame_done=0.
REQ-032 Load 16'h12AF, dp_in=4'b0001, enable=1 -> digit 0 SHOW: an_out=4'b1110, seg_out=7'h38, dp_out=0; digit 3: an_out=4'b0111, seg_out=7'h4F.
REQ-033 Load 16'h0005, blank_lz=1 -> digit 0 seg_out=7'h24 with an_out=4'b1110; an_out stays 4'hF during the digit 1..3 slots. Load 16'h0000 -> digit 0 seg_out=7'h01.
REQ-034 Steady enable -> frame_done pulses exactly once every 20 cycles, and each anode is active for 4 consecutive cycles preceded by 1 all-off cycle.
REQ-035 enable dropped during digit 2 SHOW -> next cycle in OFF, digit_idx=0; one cycle later an_out=4'hF; re-enable -> scanning restarts at digit 0.
REQ-036 rst pulsed asynchronously mid-SHOW -> outputs reach REQ-029 values before the next clock edge; load concurrent with a digit change -> the new glyph appears on the following output cycle.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 7-segment scan driver.
// Each digit gets an anode-off guard (BLANK) followed by a lit slot (SHOW).
// The digit value comes from a load-strobed shadow register, with optional
// leading-zero suppression. All pin outputs are registered.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [2:0]              digit_idx,
    output logic                    frame_done
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
    localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);
    localparam logic          INV        = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [2:0]              r_idx;
    logic                    r_frame_done;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;

    logic [3:0]              w_nibble;
    logic                    w_dp_req;
    logic                    w_blank;
    logic                    w_zero_run;
    logic [NUM_DIGITS-1:0]   w_an_sel;
    logic [6:0]              w_glyph;
    logic [6:0]              w_seg_lit;
    logic                    w_dp_lit;
    logic [NUM_DIGITS-1:0]   w_an_lit;

    // Scan sequencer: OFF/BLANK/SHOW timing, digit index and frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_OFF;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else if (!enable) begin
            r_state      <= ST_OFF;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_OFF: begin
                    r_cnt   <= '0;
                    r_state <= (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                end
                ST_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_SHOW;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        r_cnt   <= '0;
                        r_state <= (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                        if (r_idx == LAST_IDX) begin
                            r_idx        <= '0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    // Shadow register: captures the display value on the load strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow    <= '0;
            r_shadow_dp <= '0;
        end else if (load) begin
            r_shadow    <= value_in;
            r_shadow_dp <= dp_in;
        end
    end

    // Current digit select plus leading-zero detection, scanning from the top digit down.
    always_comb begin
        w_nibble   = 4'h0;
        w_dp_req   = 1'b0;
        w_blank    = 1'b0;
        w_zero_run = 1'b1;
        w_an_sel   = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            int unsigned k;
            k = NUM_DIGITS - 1 - i;
            w_zero_run = w_zero_run & (r_shadow[4*k +: 4] == 4'h0);
            if (r_idx == 3'(k)) begin
                w_nibble    = r_shadow[4*k +: 4];
                w_dp_req    = r_shadow_dp[k];
                w_blank     = blank_lz && (k != 0) && w_zero_run;
                w_an_sel[k] = 1'b1;
            end
        end
    end

    // Hex glyph table, abcdefg with 1 = lit.
    always_comb begin
        w_glyph = 7'b0000000;
        case (w_nibble)
            4'h0: w_glyph = 7'b1111110;
            4'h1: w_glyph = 7'b0110000;
            4'h2: w_glyph = 7'b1101101;
            4'h3: w_glyph = 7'b1111001;
            4'h4: w_glyph = 7'b0110011;
            4'h5: w_glyph = 7'b1011011;
            4'h6: w_glyph = 7'b1011111;
            4'h7: w_glyph = 7'b1110000;
            4'h8: w_glyph = 7'b1111111;
            4'h9: w_glyph = 7'b1111011;
            4'hA: w_glyph = 7'b1110111;
            4'hB: w_glyph = 7'b0011111;
            4'hC: w_glyph = 7'b1001110;
            4'hD: w_glyph = 7'b0111101;
            4'hE: w_glyph = 7'b1001111;
            4'hF: w_glyph = 7'b1000111;
            default: w_glyph = 7'b0000000;
        endcase
    end

    // Lit/active sense of the pins: dark except during an unblanked SHOW slot.
    always_comb begin
        w_seg_lit = 7'b0000000;
        w_dp_lit  = 1'b0;
        w_an_lit  = '0;
        if (r_state == ST_SHOW && !w_blank) begin
            w_seg_lit = w_glyph;
            w_dp_lit  = w_dp_req;
            w_an_lit  = w_an_sel;
        end
    end

    // Output registers with board polarity applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg <= {7{INV}};
            r_dp  <= INV;
            r_an  <= {NUM_DIGITS{INV}};
        end else begin
            r_seg <= w_seg_lit ^ {7{INV}};
            r_dp  <= w_dp_lit ^ INV;
            r_an  <= w_an_lit ^ {NUM_DIGITS{INV}};
        end
    end

    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign an_out     = r_an;
    assign digit_idx  = r_idx;
    assign frame_done = r_frame_done;

endmodule
